// File: rtl/pc_stack_ctrl_pkg.sv
// Shared definitions for the PC stack controller.
//   STACK_ADDR_W  : data-memory word-address width
//   STACK_SP_INIT : stack pointer after reset (stack grows downward)
//   STACK_WORDS   : words per stack frame (2, or 3 when FLAGS_SAVE_EN is defined)
//   state_t       : controller FSM states
//   rd_tag_t      : identifies which frame word a pending read returns
// Optional feature macro: FLAGS_SAVE_EN
package pc_stack_ctrl_pkg;

    localparam int STACK_ADDR_W = 20;
    localparam logic [STACK_ADDR_W-1:0] STACK_SP_INIT = 20'hFFFFF;

`ifdef FLAGS_SAVE_EN
    localparam int STACK_WORDS = 3;
`else
    localparam int STACK_WORDS = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_FL = 3'd1,
        S_PUSH_HI = 3'd2,
        S_PUSH_LO = 3'd3,
        S_POP_LO  = 3'd4,
        S_POP_HI  = 3'd5,
        S_POP_FL  = 3'd6,
        S_POP_END = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LO   = 2'd1,
        TAG_HI   = 2'd2,
        TAG_FL   = 2'd3
    } rd_tag_t;

endpackage

// File: rtl/pc_stack_ctrl_sp_reg.sv
// Stack pointer register with boundary compares.
// Ports:
//   clk       in   clock, rising edge
//   load_init in   load SP_INIT (used as the synchronous reset)
//   inc1/inc2 in   add 1 / add 2 (both together add 3)
//   dec1      in   subtract 1 (wins over increments)
//   sp        out  current stack pointer
//   sp_plus1/2 out precomputed pop read addresses
//   push_ok   out  a full frame fits below SP
//   pop_ok    out  a full frame exists above SP
module pc_stack_ctrl_sp_reg
    import pc_stack_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = STACK_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT = STACK_SP_INIT
) (
    input  logic              clk,
    input  logic              load_init,
    input  logic              inc1,
    input  logic              inc2,
    input  logic              dec1,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic [ADDR_W-1:0] sp_plus2,
    output logic              push_ok,
    output logic              pop_ok
);

    logic [ADDR_W-1:0] inc_amt;

    always_comb begin
        inc_amt  = ADDR_W'({inc2, inc1});
        sp_plus1 = sp + ADDR_W'(1);
        sp_plus2 = sp + ADDR_W'(2);
        // Push writes SP down to SP-(WORDS-1); pop reads up to SP+WORDS.
        push_ok  = (sp >= ADDR_W'(STACK_WORDS - 1));
        pop_ok   = (sp <= SP_INIT - ADDR_W'(STACK_WORDS));
    end

    always_ff @(posedge clk) begin
        if (load_init) begin
            sp <= SP_INIT;
        end else if (dec1) begin
            sp <= sp - ADDR_W'(1);
        end else begin
            sp <= sp + inc_amt;
        end
    end

endmodule

// File: rtl/pc_stack_ctrl.sv
// Stack side of the fetch-stage PC restore path.
// CALL/INT pushes the return PC (high word first, at the higher address);
// RET/RTI reads it back and hands the halves to fetch.
// Ports:
//   clk, rst (sync, active-low)
//   push_req/pop_req  1-cycle requests, honoured only in IDLE (push wins)
//   ret_pc, flags_in  frame contents, sampled when a push is accepted
//   mem_*             data-memory port; combinational from state and SP
//   pop_pc_low_sig/pop_pc_high_sig/flags_restore/pop_data  restored words
//   stall, done, stack_err  status (registered)
// Optional feature macro: FLAGS_SAVE_EN (saves/restores flags as a third word).
//
// Handshake: a request is taken on the rising edge where it is high and
// the controller is IDLE; stall is high for every non-IDLE cycle and done
// marks the last one. Read data is registered, so each pop_* strobe shows
// in the cycle after its word comes back from memory.
module pc_stack_ctrl
    import pc_stack_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = STACK_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_INIT = STACK_SP_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [31:0]       ret_pc,
    input  logic [15:0]       flags_in,
    input  logic [15:0]       mem_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              pop_pc_low_sig,
    output logic              pop_pc_high_sig,
    output logic [15:0]       pop_data,
    output logic              flags_restore,
    output logic              stall,
    output logic              done,
    output logic              stack_err
);

`ifdef FLAGS_SAVE_EN
    localparam state_t PUSH_FIRST   = S_PUSH_FL;
    localparam state_t POP_AFTER_HI = S_POP_FL;
    logic [15:0] flags_q;
`else
    localparam state_t PUSH_FIRST   = S_PUSH_HI;
    localparam state_t POP_AFTER_HI = S_POP_END;
    logic unused_flags;
    assign unused_flags  = ^flags_in;
    assign flags_restore = 1'b0;
`endif

    state_t      state, state_nx;
    rd_tag_t     tag_q, tag_nx;
    // abort_q: the boundary check failed, so the sequence runs its cycles
    // without touching memory or SP.
    logic        abort_q, abort_nx;
    logic        err_set;
    logic [31:0] pc_q;

    logic [ADDR_W-1:0] sp, sp_plus1, sp_plus2;
    logic              push_ok, pop_ok;
    logic              sp_inc1, sp_inc2, sp_dec1;

    pc_stack_ctrl_sp_reg #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
        .clk      (clk),
        .load_init(!rst),
        .inc1     (sp_inc1),
        .inc2     (sp_inc2),
        .dec1     (sp_dec1),
        .sp       (sp),
        .sp_plus1 (sp_plus1),
        .sp_plus2 (sp_plus2),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok)
    );

    always_comb begin
        state_nx  = state;
        abort_nx  = abort_q;
        tag_nx    = TAG_NONE;
        err_set   = 1'b0;
        sp_inc1   = 1'b0;
        sp_inc2   = 1'b0;
        sp_dec1   = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'h0;
        case (state)
            S_IDLE: begin
                if (push_req) begin
                    state_nx = PUSH_FIRST;
                    abort_nx = !push_ok;
                    err_set  = !push_ok;
                end else if (pop_req) begin
                    state_nx = S_POP_LO;
                    abort_nx = !pop_ok;
                    err_set  = !pop_ok;
                end
            end
`ifdef FLAGS_SAVE_EN
            S_PUSH_FL: begin
                if (!abort_q) begin
                    mem_wr    = 1'b1;
                    mem_addr  = sp;
                    mem_wdata = flags_q;
                    sp_dec1   = 1'b1;
                end
                state_nx = S_PUSH_HI;
            end
            S_POP_FL: begin
                if (!abort_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = sp + ADDR_W'(3);
                    tag_nx   = TAG_FL;
                end
                state_nx = S_POP_END;
            end
`endif
            S_PUSH_HI: begin
                if (!abort_q) begin
                    mem_wr    = 1'b1;
                    mem_addr  = sp;
                    mem_wdata = pc_q[31:16];
                    sp_dec1   = 1'b1;
                end
                state_nx = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                if (!abort_q) begin
                    mem_wr    = 1'b1;
                    mem_addr  = sp;
                    mem_wdata = pc_q[15:0];
                    sp_dec1   = 1'b1;
                end
                state_nx = S_IDLE;
            end
            S_POP_LO: begin
                if (!abort_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = sp_plus1;
                    tag_nx   = TAG_LO;
                end
                state_nx = S_POP_HI;
            end
            S_POP_HI: begin
                if (!abort_q) begin
                    mem_rd   = 1'b1;
                    mem_addr = sp_plus2;
                    tag_nx   = TAG_HI;
                end
                state_nx = POP_AFTER_HI;
            end
            S_POP_END: begin
                // Release the whole frame at once; reads above used the old SP.
                if (!abort_q) begin
                    sp_inc2 = 1'b1;
                    sp_inc1 = (STACK_WORDS == 3);
                end
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            tag_q           <= TAG_NONE;
            abort_q         <= 1'b0;
            pc_q            <= 32'h0;
            stall           <= 1'b0;
            done            <= 1'b0;
            pop_pc_low_sig  <= 1'b0;
            pop_pc_high_sig <= 1'b0;
            pop_data        <= 16'h0;
            stack_err       <= 1'b0;
`ifdef FLAGS_SAVE_EN
            flags_q         <= 16'h0;
            flags_restore   <= 1'b0;
`endif
        end else begin
            state           <= state_nx;
            tag_q           <= tag_nx;
            abort_q         <= abort_nx;
            if (state == S_IDLE && push_req) begin
                pc_q <= ret_pc;
`ifdef FLAGS_SAVE_EN
                flags_q <= flags_in;
`endif
            end
            // Lookahead on next state keeps stall/done aligned with the state.
            stall           <= (state_nx != S_IDLE);
            done            <= (state_nx == S_PUSH_LO) || (state_nx == S_POP_END);
            // tag_q says which word mem_rdata carries this cycle.
            pop_pc_low_sig  <= (tag_q == TAG_LO);
            pop_pc_high_sig <= (tag_q == TAG_HI);
            pop_data        <= (tag_q == TAG_NONE) ? 16'h0 : mem_rdata;
`ifdef FLAGS_SAVE_EN
            flags_restore   <= (tag_q == TAG_FL);
`endif
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_ctrl.sv
module tb_pc_stack_ctrl;

`ifdef FLAGS_SAVE_EN
    localparam int WORDS = 3;
`else
    localparam int WORDS = 2;
`endif
    localparam logic [19:0] SP_TOP = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_req = 1'b0, pop_req = 1'b0;
    logic [31:0] ret_pc = 32'h0;
    logic [15:0] flags_in = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_wr, mem_rd;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        pop_pc_low_sig, pop_pc_high_sig, flags_restore;
    logic [15:0] pop_data;
    logic        stall, done, stack_err;

    pc_stack_ctrl dut (
        .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
        .ret_pc(ret_pc), .flags_in(flags_in), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pop_pc_low_sig(pop_pc_low_sig),
        .pop_pc_high_sig(pop_pc_high_sig), .pop_data(pop_data),
        .flags_restore(flags_restore), .stall(stall), .done(done),
        .stack_err(stack_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- data memory ----------------
    logic [15:0] ram [int];

    function automatic logic [15:0] init_word(input int a);
        return 16'(a) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (mem_wr) ram[int'(mem_addr)] = mem_wdata;
        if (mem_rd)
            mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_word(int'(mem_addr));
        else
            mem_rdata <= 16'($urandom);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic        lo;
        logic        hi;
        logic        fl;
        logic [15:0] data;
        logic        done;
        logic        stall;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_mem [int];
    logic [19:0] m_sp = SP_TOP;
    logic        m_err = 1'b0;
    logic        model_idle = 1'b1;
    logic        checking = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] m_read(input int a);
        return m_mem.exists(a) ? m_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level view: a push writes its words top-down from SP; a pop
    // reads them back bottom-up and each word shows two cycles after its read.
    task automatic model_step(input logic p, input logic q, input logic r,
                              input logic [31:0] pc, input logic [15:0] fl);
        exp_t        e;
        logic        ok;
        logic [15:0] w [3];
        if (!r) begin
            exp_q.delete();
            m_sp  = SP_TOP;
            m_err = 1'b0;
            return;
        end
        if (!model_idle) return;
        if (p) begin
            ok = (m_sp >= 20'(WORDS - 1));
`ifdef FLAGS_SAVE_EN
            w[0] = fl; w[1] = pc[31:16]; w[2] = pc[15:0];
`else
            w[0] = pc[31:16]; w[1] = pc[15:0]; w[2] = fl;
`endif
            for (int i = 0; i < WORDS; i++) begin
                e = '0;
                e.stall = 1'b1;
                e.done  = (i == WORDS - 1);
                if (ok) begin
                    e.wr = 1'b1; e.addr = m_sp - 20'(i); e.wdata = w[i];
                end
                exp_q.push_back(e);
            end
            if (ok) m_sp = m_sp - 20'(WORDS); else m_err = 1'b1;
        end else if (q) begin
            ok = (m_sp <= SP_TOP - 20'(WORDS));
            for (int i = 0; i < WORDS + 2; i++) begin
                if (!ok && i == WORDS + 1) break;
                e = '0;
                e.stall = (i <= WORDS);
                e.done  = (i == WORDS);
                if (ok && i < WORDS) begin
                    e.rd = 1'b1; e.addr = m_sp + 20'(i + 1);
                end
                if (ok && i >= 2) begin
                    e.lo = (i == 2); e.hi = (i == 3); e.fl = (i == 4);
                    e.data = m_read(int'(m_sp) + i - 1);
                end
                exp_q.push_back(e);
            end
            if (ok) m_sp = m_sp + 20'(WORDS); else m_err = 1'b1;
        end
    endtask

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin : compare
        exp_t e;
        if (checking) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("mem_wr",    32'(mem_wr),          32'(e.wr));
            check("mem_rd",    32'(mem_rd),          32'(e.rd));
            check("mem_addr",  32'(mem_addr),        32'(e.addr));
            check("mem_wdata", 32'(mem_wdata),       32'(e.wdata));
            check("pop_lo",    32'(pop_pc_low_sig),  32'(e.lo));
            check("pop_hi",    32'(pop_pc_high_sig), 32'(e.hi));
            check("flags_rst", 32'(flags_restore),   32'(e.fl));
            check("pop_data",  32'(pop_data),        32'(e.data));
            check("done",      32'(done),            32'(e.done));
            check("stall",     32'(stall),           32'(e.stall));
            check("stack_err", 32'(stack_err),       32'(m_err));
            if (e.wr) m_mem[int'(e.addr)] = e.wdata;
            model_idle = !e.stall;
        end
    end

    // ---------------- driver ----------------
    task automatic do_cycle(input logic p, input logic q, input logic r,
                            input logic [31:0] pc, input logic [15:0] fl);
        push_req = p;
        pop_req  = q;
        rst      = r;
        ret_pc   = pc;
        flags_in = fl;
        model_step(p, q, r, pc, fl);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b1, 32'h0, 16'h0);
    endtask

    logic [31:0] dir_pc;
    logic [15:0] dir_fl;
    logic [15:0] push_words [3];
    logic [15:0] pop_words  [3];

    initial begin
        dir_pc = 32'h0001_0ABC;
        dir_fl = 16'h0005;
`ifdef FLAGS_SAVE_EN
        push_words[0] = 16'h0005; push_words[1] = 16'h0001; push_words[2] = 16'h0ABC;
`else
        push_words[0] = 16'h0001; push_words[1] = 16'h0ABC; push_words[2] = 16'h0000;
`endif
        pop_words[0] = 16'h0ABC; pop_words[1] = 16'h0001; pop_words[2] = 16'h0005;

        // reset
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        checking = 1'b1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err",   32'(stack_err), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);

        // push 0x0001_0ABC from reset
        do_cycle(1'b1, 1'b0, 1'b1, dir_pc, dir_fl);
        for (int i = 0; i < WORDS; i++) begin
            check("push_wr",    32'(mem_wr), 32'd1);
            check("push_addr",  32'(mem_addr), 32'(20'hFFFFF - 20'(i)));
            check("push_wdata", 32'(mem_wdata), 32'(push_words[i]));
            check("push_done",  32'(done), 32'(i == WORDS - 1));
            idle(1);
        end
        check("push_idle", 32'(stall), 32'd0);

        // pop it straight back
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 16'h0);
        for (int i = 0; i < WORDS + 2; i++) begin
            check("pop_rd",    32'(mem_rd), 32'(i < WORDS));
            check("pop_stall", 32'(stall), 32'(i <= WORDS));
            check("pop_done",  32'(done), 32'(i == WORDS));
            if (i < WORDS) check("pop_addr", 32'(mem_addr), 32'(20'hFFFFF - 20'(WORDS) + 20'(i + 1)));
            if (i >= 2) begin
                check("pop_word", 32'(pop_data), 32'(pop_words[i - 2]));
                check("pop_lo_s", 32'(pop_pc_low_sig), 32'(i == 2));
                check("pop_hi_s", 32'(pop_pc_high_sig), 32'(i == 3));
            end
            idle(1);
        end

        // push+pop together: push wins; pop during stall is ignored
        do_cycle(1'b1, 1'b1, 1'b1, 32'hCAFE_1234, 16'h00A0);
        check("both_wr", 32'(mem_wr), 32'd1);
        check("both_rd", 32'(mem_rd), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 16'h0);
        idle(WORDS - 1);
        check("ign_stall", 32'(stall), 32'd0);
        check("ign_rd",    32'(mem_rd), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 16'h0);
        idle(WORDS + 1);

        // pop on empty stack
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 16'h0);
        check("uf_rd",  32'(mem_rd), 32'd0);
        check("uf_err", 32'(stack_err), 32'd1);
        idle(WORDS);
        check("uf_done", 32'(done), 32'd1);
        check("uf_lo",   32'(pop_pc_low_sig), 32'd0);
        idle(6);
        check("uf_sticky", 32'(stack_err), 32'd1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        check("uf_clr", 32'(stack_err), 32'd0);

        // reset during POP_HI
        do_cycle(1'b1, 1'b0, 1'b1, 32'h1357_9BDF, 16'h0011);
        idle(WORDS);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 16'h0);
        idle(1);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_rd",    32'(mem_rd), 32'd0);
        check("abort_data",  32'(pop_data), 32'd0);
        check("abort_lo",    32'(pop_pc_low_sig), 32'd0);
        do_cycle(1'b1, 1'b0, 1'b1, dir_pc, dir_fl);
        check("restart_addr", 32'(mem_addr), 32'(20'hFFFFF));
        check("restart_wr",   32'(mem_wr), 32'd1);
        idle(WORDS);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 150) != 0, $urandom, 16'($urandom));
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
